btn_1hot_to_bcd_2bit: RTL

Debounced one-hot to 2-bit binary encoder for the timer's 4-button panel. It is the inverse of the 2-bit to one-hot decoder: four asynchronous button lines, at most one of which should be active, become a registered 2-bit code with a VALID/ACK handshake. Multi-hot presses and presses that arrive while a previous code is still unacknowledged are reported as error pulses. It sits between the board's button pins and the timer control FSM.

---
 rtl/btn_1hot_to_bcd_2bit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/btn_1hot_to_bcd_2bit.sv
// Debounced one-hot button encoder: 4 raw button lines in, registered 2-bit
// code out with a VALID/ACK handshake plus ERR (multi-hot) and OVR (dropped) pulses.
module btn_1hot_to_bcd_2bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_i,
  input  logic       ack_i,
  output logic [1:0] out_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       ovr_o
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  s1_q, s2_q;
  logic [3:0]  smp_q, smp_d;
  logic [19:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  out_q, out_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;
  logic        accept;
  logic        onehot;
  logic [1:0]  enc;

  // Two-flop synchronizer; only s2_q is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 4'd0;
      s2_q <= 4'd0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      smp_q   <= 4'd0;
      cnt_q   <= 20'd0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q != 4'd0) begin
          smp_d   = s2_q;
          cnt_d   = 20'd1;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s2_q == 4'd0) begin
          state_d = IDLE;
        end else if (s2_q != smp_q) begin
          smp_d = s2_q;
          cnt_d = 20'd1;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        // Pattern changes while held are ignored until a full release.
        if (s2_q == 4'd0) begin
          cnt_d   = 20'd1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (s2_q != 4'd0)          state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  assign onehot = (smp_q != 4'd0) && ((smp_q & (smp_q - 4'd1)) == 4'd0);

  always_comb begin
    case (smp_q)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  // A same-edge ACK frees the slot, so a fresh code then wins over the clear.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q && !ack_i;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    if (accept) begin
      if (!onehot) begin
        err_d   = 1'b1;
        valid_d = valid_q && !ack_i;
      end else if (valid_q && !ack_i) begin
        ovr_d = 1'b1;
      end else begin
        out_d   = enc;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 2'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign ovr_o   = ovr_q;

endmodule
